// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants and types for the dispatch/issue hazard controller
package hazard_pkg;
  localparam int FU_LDST    = 0;
  localparam int FU_ALU     = 1;
  localparam int NUM_FU_DEF = 3;
  localparam int BR_CNT_W   = 4;

  typedef logic [NUM_FU_DEF-1:0] fu_vec_t;
endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up/down counter saturating at 0 and MAX, with clear overriding both
module sat_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] count
);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Simultaneous inc and dec cancel out.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec && count_q != MAX_V) begin
      count_d = count_q + W'(1);
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - dispatch enables, execute stalls, branch tracking and memory-port
// arbitration with fetch-starvation guard
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int NUM_FU     = NUM_FU_DEF,
  parameter int MAX_BR     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                is_valid_inst,
  input  logic [NUM_FU-1:0]   is_fu_sel,
  input  logic                is_branch,
  input  logic [NUM_FU-1:0]   rs_full,
  input  logic                rob_full,
  input  logic                br_resolve,
  input  logic                br_mispredict,
  input  logic [NUM_FU-1:0]   wr_valid,
  input  logic [NUM_FU-1:0]   wr_written,
  input  logic                acu_wr_mem,
  input  logic                acu_rd_mem,
  input  logic                lb_full,
  input  logic                commit_wr_mem,
  input  logic                lb_read_mem,
  input  logic                dmem_wait,
  output logic [NUM_FU-1:0]   rs_enable,
  output logic                rob_enable,
  output logic [NUM_FU-1:0]   exec_stall,
  output logic [NUM_FU-1:0]   wr_enable,
  output logic                lb_exec_stall,
  output logic                if_enable,
  output logic                if_is_enable,
  output logic                if_is_flush,
  output logic [BR_CNT_W-1:0] br_count
);
  logic [BR_CNT_W-1:0] starve_cnt;
  logic                is_stall;
  logic                mispred;
  logic                dispatch;
  logic                br_inc;
  logic                br_dec;
  logic                br_clr;
  logic                starved;
  logic                mem_hazard;
  logic                fetch_grant;

  always_comb begin
    wr_enable             = ~wr_valid | wr_written;
    exec_stall            = ~wr_enable;
    exec_stall[FU_LDST]   = (acu_wr_mem & ~wr_enable[FU_LDST]) | (acu_rd_mem & lb_full);

    // Only branches are held back by the in-flight limit.
    is_stall = rob_full | (|(is_fu_sel & rs_full))
             | (is_branch & (br_count == BR_CNT_W'(MAX_BR)));
    mispred  = br_resolve & br_mispredict;
    dispatch = is_valid_inst & ~is_stall & ~mispred;

    rs_enable  = dispatch ? is_fu_sel : '0;
    rob_enable = dispatch;

    br_inc = dispatch & is_branch;
    br_dec = br_resolve & ~exec_stall[FU_ALU];
    br_clr = mispred & ~exec_stall[FU_ALU];

    // Stores at commit always win; a starved fetch then beats the load buffer.
    starved     = (starve_cnt == BR_CNT_W'(STARVE_MAX));
    mem_hazard  = commit_wr_mem | (lb_read_mem & ~dmem_wait & ~starved);
    fetch_grant = ~(mem_hazard | is_stall);

    lb_exec_stall = commit_wr_mem | ~wr_enable[FU_LDST] | dmem_wait | (starved & ~commit_wr_mem);
    if_enable     = fetch_grant;
    if_is_enable  = ~is_stall;
    if_is_flush   = mispred | (mem_hazard & ~is_stall);
  end

  sat_counter #(
    .W   (BR_CNT_W),
    .MAX (MAX_BR)
  ) u_br_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (br_inc),
    .dec   (br_dec),
    .clr   (br_clr),
    .count (br_count)
  );

  sat_counter #(
    .W   (BR_CNT_W),
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (mem_hazard & ~is_stall),
    .dec   (1'b0),
    .clr   (fetch_grant),
    .count (starve_cnt)
  );

  a_br_no_underflow : assert property (
    @(posedge clock) disable iff (!reset)
    (br_dec && !br_inc && !br_clr) |-> (br_count != '0)
  );
endmodule
